// File: rtl/afe_spi_master.sv
// 8-bit mode-0 SPI master for the AFE CPLD: shifts a GPIO byte out on MOSI while
// capturing the TOT counter from MISO; CS_B rising commits the byte in the AFE.
module afe_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_B,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RX_DATA,
    output logic       CS_B,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  rx_q, rx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_b_q, cs_b_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        last_div, last_gap;

    assign last_div = (phase_q == PW'(CLK_DIV - 1));
    assign last_gap = (phase_q == PW'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PW'(1);
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_sr_d = rx_sr_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_b_d  = cs_b_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (START) begin
                    tx_d    = TX_DATA;
                    cs_b_d  = 1'b0;
                    mosi_d  = TX_DATA[7];
                    busy_d  = 1'b1;
                    bit_d   = 3'd7;
                    state_d = S_SETUP;
                end
            end
            // MISO is captured on the same CLK edge that raises SCLK, i.e. the AFE's pre-edge value
            S_SETUP, S_LOW: begin
                if (last_div) begin
                    phase_d = '0;
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[6:0], MISO};
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (last_div) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    if (bit_q == 3'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        mosi_d  = tx_q[bit_q - 3'd1];
                        bit_d   = bit_q - 3'd1;
                        state_d = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (last_div) begin
                    phase_d = '0;
                    cs_b_d  = 1'b1;
                    mosi_d  = 1'b0;
                    rx_d    = rx_sr_q;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (last_gap) begin
                    phase_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                phase_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_sr_q <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_b_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_sr_q <= rx_sr_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_b_q  <= cs_b_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RX_DATA = rx_q;
    assign CS_B    = cs_b_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Bench for afe_spi_master: two instances (default timing and CLK_DIV=GAP_CYCLES=1),
// each with a bus-functional AFE and a frame-timing reference model.
module tb_afe_spi_master;

    localparam int NI = 2;
    localparam int DIV  [NI] = '{4, 1};
    localparam int GAPC [NI] = '{4, 1};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_b [NI];
    logic       start [NI];
    logic [7:0] txd   [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic [7:0] rxd   [NI];
    logic       cs_b  [NI];
    logic       sclk  [NI];
    logic       mosi  [NI];
    logic       miso  [NI];

    afe_spi_master #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut0 (
        .CLK(CLK), .RST_B(rst_b[0]), .START(start[0]), .TX_DATA(txd[0]),
        .BUSY(busy[0]), .DONE(done[0]), .RX_DATA(rxd[0]),
        .CS_B(cs_b[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    afe_spi_master #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RST_B(rst_b[1]), .START(start[1]), .TX_DATA(txd[1]),
        .BUSY(busy[1]), .DONE(done[1]), .RX_DATA(rxd[1]),
        .CS_B(cs_b[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tmo_cnt = 0;
    int tmo_seen = 0;

    // AFE bus-functional state
    logic [7:0] tot     [NI];
    logic [7:0] afe_sr  [NI];
    logic [7:0] gpio_sr [NI];
    logic [7:0] gpio    [NI];
    int         rises   [NI];
    logic       cs_prev [NI];
    logic       sclk_prev [NI];

    // Reference model: a frame is just an accept edge plus the latched bytes
    bit         valid [NI];
    bit         act   [NI];
    int         a     [NI];
    logic [7:0] m_tx  [NI];
    logic [7:0] m_tot [NI];
    logic [7:0] rx_exp [NI];
    int         gchk_cyc [NI];
    logic [7:0] gchk_val [NI];

    // Hand-computed expectations for the directed frames
    int         lit_rise [NI];
    int         lit_done [NI];
    int         lit_busy [NI];
    logic [7:0] lit_rx   [NI];
    logic [7:0] lit_gpio [NI];

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", nm, inst, cyc, got, exp);
        end
    endtask

    always @(posedge CLK) begin
        int m;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (!rst_b[i]) begin
                act[i]    = 1'b0;
                rx_exp[i] = 8'h00;
                valid[i]  = 1'b1;
            end else if (act[i]) begin
                m = cyc - a[i];
                if (m == 17 * DIV[i]) begin
                    rx_exp[i]   = m_tot[i];
                    gchk_cyc[i] = cyc + 1;
                    gchk_val[i] = m_tx[i];
                end
                if (m == 17 * DIV[i] + GAPC[i]) act[i] = 1'b0;
            end else if (start[i]) begin
                act[i]   = 1'b1;
                a[i]     = cyc;
                m_tx[i]  = txd[i];
                m_tot[i] = tot[i];
            end
        end
    end

    always @(negedge CLK) begin
        int   m, j, d;
        logic e_busy, e_cs, e_sclk, e_mosi, e_done;
        for (int i = 0; i < NI; i++) begin
            if (valid[i]) begin
                d = DIV[i];
                if (act[i]) begin
                    m      = cyc - a[i];
                    j      = m / (2 * d);
                    if (j > 7) j = 7;
                    e_busy = 1'b1;
                    e_cs   = (m >= 17 * d);
                    e_sclk = (m < 16 * d) && (((m / d) % 2) == 1);
                    e_mosi = (m < 17 * d) ? m_tx[i][7 - j] : 1'b0;
                    e_done = (m == 17 * d);
                end else begin
                    e_busy = 1'b0;
                    e_cs   = 1'b1;
                    e_sclk = 1'b0;
                    e_mosi = 1'b0;
                    e_done = 1'b0;
                end
                chk("BUSY", i, 32'(busy[i]), 32'(e_busy));
                chk("CS_B", i, 32'(cs_b[i]), 32'(e_cs));
                chk("SCLK", i, 32'(sclk[i]), 32'(e_sclk));
                chk("MOSI", i, 32'(mosi[i]), 32'(e_mosi));
                chk("DONE", i, 32'(done[i]), 32'(e_done));
                chk("RX_DATA", i, 32'(rxd[i]), 32'(rx_exp[i]));
                if (cyc == gchk_cyc[i]) chk("GPIO", i, 32'(gpio[i]), 32'(gchk_val[i]));
                if (cyc == lit_rise[i] - 1) chk("LIT_SCLK_PRE", i, 32'(sclk[i]), 32'd0);
                if (cyc == lit_rise[i])     chk("LIT_SCLK_RISE", i, 32'(sclk[i]), 32'd1);
                if (cyc == lit_done[i]) begin
                    chk("LIT_DONE", i, 32'(done[i]), 32'd1);
                    chk("LIT_RX", i, 32'(rxd[i]), 32'(lit_rx[i]));
                    chk("LIT_RISES", i, 32'(rises[i]), 32'd8);
                    chk("LIT_MOSI_BITS", i, 32'(gpio_sr[i]), 32'(lit_gpio[i]));
                end
                if (cyc == lit_done[i] + 1) chk("LIT_GPIO", i, 32'(gpio[i]), 32'(lit_gpio[i]));
                if (cyc == lit_busy[i] - 1) chk("LIT_BUSY_HI", i, 32'(busy[i]), 32'd1);
                if (cyc == lit_busy[i])     chk("LIT_BUSY_LO", i, 32'(busy[i]), 32'd0);
            end
        end
        if (tmo_cnt != tmo_seen) begin
            tests++;
            fails++;
            $display("FAIL TIMEOUT cyc=%0d got=%0d timeouts want=0", cyc, tmo_cnt);
            tmo_seen = tmo_cnt;
        end
        for (int i = 0; i < NI; i++) begin
            if (cs_prev[i] === 1'b1 && cs_b[i] === 1'b0) begin
                afe_sr[i] = tot[i];
                rises[i]  = 0;
            end else if (cs_b[i] === 1'b0 && sclk_prev[i] === 1'b0 && sclk[i] === 1'b1) begin
                gpio_sr[i] = {gpio_sr[i][6:0], mosi[i]};
                afe_sr[i]  = {afe_sr[i][6:0], 1'b0};
                rises[i]   = rises[i] + 1;
            end
            if (cs_prev[i] === 1'b0 && cs_b[i] === 1'b1) gpio[i] = gpio_sr[i];
            miso[i]      = (cs_b[i] === 1'b0) ? afe_sr[i][7] : 1'b0;
            cs_prev[i]   = cs_b[i];
            sclk_prev[i] = sclk[i];
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) tmo_cnt++;
    endtask

    task automatic pulse(input int i, input logic [7:0] tx, input logic [7:0] t);
        txd[i]   = tx;
        tot[i]   = t;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic set_lits(input int i, input int t0, input logic [7:0] rx, input logic [7:0] g);
        lit_rise[i] = t0 + 1 + DIV[i];
        lit_done[i] = t0 + 1 + 17 * DIV[i];
        lit_busy[i] = t0 + 1 + 17 * DIV[i] + GAPC[i];
        lit_rx[i]   = rx;
        lit_gpio[i] = g;
    endtask

    initial begin
        int t0, k, hold;
        for (int i = 0; i < NI; i++) begin
            rst_b[i] = 1'b0; start[i] = 1'b0; txd[i] = 8'h00; tot[i] = 8'h00;
            lit_rise[i] = -100; lit_done[i] = -100; lit_busy[i] = -100;
            gchk_cyc[i] = -100;
        end
        repeat (3) tick();
        for (int i = 0; i < NI; i++) rst_b[i] = 1'b1;
        repeat (8) tick();

        // Default timing frame: TX=0xA5, TOT=0x3C
        t0 = cyc;
        set_lits(0, t0, 8'h3C, 8'hA5);
        pulse(0, 8'hA5, 8'h3C);
        repeat (10) tick();
        txd[0] = 8'h11; start[0] = 1'b1; tick(); start[0] = 1'b0;
        wait_idle(0);
        repeat (3) tick();

        // START held high: back-to-back frames
        txd[0] = 8'hC3; tot[0] = 8'h5A; start[0] = 1'b1;
        repeat (3 * (17 * 4 + 4 + 1) + 5) tick();
        start[0] = 1'b0;
        wait_idle(0);
        repeat (2) tick();

        // Reset one cycle after the third SCLK rising edge
        pulse(0, 8'h96, 8'hE7);
        repeat (20) tick();
        rst_b[0] = 1'b0; tick(); rst_b[0] = 1'b1;
        repeat (3) tick();
        t0 = cyc;
        set_lits(0, t0, 8'h00, 8'h0F);
        pulse(0, 8'h0F, 8'h00);
        wait_idle(0);
        repeat (2) tick();

        // TOT all-zero then all-one
        pulse(0, 8'h33, 8'h00);
        wait_idle(0);
        t0 = cyc;
        set_lits(0, t0, 8'hFF, 8'hCC);
        pulse(0, 8'hCC, 8'hFF);
        wait_idle(0);
        repeat (2) tick();

        // Fastest timing: MSB alignment with TOT=0x80
        t0 = cyc;
        set_lits(1, t0, 8'h80, 8'hFF);
        pulse(1, 8'hFF, 8'h80);
        wait_idle(1);
        repeat (2) tick();

        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 1));
            wait_idle(k);
            txd[k] = 8'($urandom);
            tot[k] = 8'($urandom);
            start[k] = 1'b1;
            hold = int'($urandom_range(1, 3));
            repeat (hold) tick();
            start[k] = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 60)) tick();
                rst_b[k] = 1'b0; tick(); rst_b[k] = 1'b1;
            end
        end
        wait_idle(0);
        wait_idle(1);
        repeat (10) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
